// File: rtl/ram_bank_pkg.sv
// ram_bank_pkg: shared types and helpers for the ram_bank register memory
package ram_bank_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam int MAX_WIDTH = 64;
  function automatic int aw_of(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic logic even_par(input logic [MAX_WIDTH-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/ram_word.sv
// ram_word: one storage word with async reset, write enable and synchronous clear
module ram_word #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/ram_bank.sv
// ram_bank: WIDTH x DEPTH register bank with req/ack access port and clear sweep
// Define RAM_BANK_PARITY_EN to store an even-parity bit per word and expose perr.
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = aw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr,
  output logic             ack,
  output logic [WIDTH-1:0] rdata,
`ifdef RAM_BANK_PARITY_EN
  output logic             perr,
`endif
  output logic             busy
);
`ifdef RAM_BANK_PARITY_EN
  localparam int WW = WIDTH + 1;
`else
  localparam int WW = WIDTH;
`endif
  state_t state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [WW-1:0] q [DEPTH];
  logic [WW-1:0] wword, rword;
  logic acc, wr, rd, in_range, last;
  assign busy     = state == ST_CLEAR;
  assign acc      = !busy && req && !clr;
  assign wr       = acc && we;
  assign rd       = acc && !we;
  assign in_range = int'(addr) < DEPTH;
  assign last     = ptr == AW'(DEPTH - 1);
  assign rword    = in_range ? q[addr] : '0;
`ifdef RAM_BANK_PARITY_EN
  assign wword = {even_par(MAX_WIDTH'(wdata)), wdata};
`else
  assign wword = wdata;
`endif
  for (genvar i = 0; i < DEPTH; i++) begin : g_w
    ram_word #(.W(WW)) u_w (
      .clk (clk),
      .rst (rst),
      .we  (wr && addr == AW'(i)),
      .clr (busy && ptr == AW'(i)),
      .d   (wword),
      .q   (q[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  always_comb begin
    state_n = busy ? (last ? ST_IDLE : ST_CLEAR) : (clr ? ST_CLEAR : ST_IDLE);
    ptr_n   = (busy && !last) ? ptr + 1'b1 : '0;
  end
  // rdata only moves on reads; it holds across writes and idle cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= acc;
      if (rd) rdata <= rword[WIDTH-1:0];
    end
`ifdef RAM_BANK_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) perr <= 1'b0;
    else perr <= rd && ^rword;
`endif
endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: randomized and directed check of ram_bank against an array model
module tb_ram_bank;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  logic clk = 0, rst, req, we, clr, ack, busy;
  logic [2:0] addr;
  logic [7:0] wdata, rdata;
`ifdef RAM_BANK_PARITY_EN
  logic perr;
`endif
  int errs = 0, checks = 0;
  logic [7:0] mmem [DEPTH];
  bit mbad [DEPTH];
  bit mbusy, mack, mperr;
  int mptr;
  logic [7:0] mrd;
  always #5 clk = ~clk;
  ram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .clr(clr), .ack(ack), .rdata(rdata),
`ifdef RAM_BANK_PARITY_EN
    .perr(perr),
`endif
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mmem[i] = 0;
      mbad[i] = 0;
    end
    mbusy = 0; mack = 0; mperr = 0; mptr = 0; mrd = 0;
  endtask
  task automatic step(input logic r, input logic w, input logic [2:0] a,
                      input logic [7:0] d, input logic c, input string tag);
    req = r; we = w; addr = a; wdata = d; clr = c;
    @(posedge clk);
    mperr = 0;
    if (mbusy) begin
      mmem[mptr] = 0;
      mbad[mptr] = 0;
      mptr++;
      if (mptr == DEPTH) mbusy = 0;
      mack = 0;
    end else if (c) begin
      mbusy = 1;
      mptr = 0;
      mack = 0;
    end else begin
      mack = r;
      if (r && w && a < DEPTH) begin
        mmem[a] = d;
        mbad[a] = 0;
      end
      if (r && !w) begin
        mrd = a < DEPTH ? mmem[a] : 8'h00;
        mperr = a < DEPTH && mbad[a];
      end
    end
    #1;
    chk({tag, ".ack"}, ack, mack);
    chk({tag, ".busy"}, busy, mbusy);
    chk({tag, ".rdata"}, rdata, mrd);
`ifdef RAM_BANK_PARITY_EN
    chk({tag, ".perr"}, perr, mperr);
`endif
    req = 0; clr = 0;
  endtask
  initial begin
    int n;
    rst = 1; req = 0; we = 0; clr = 0; addr = 0; wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst.ack", ack, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rdata", rdata, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 3'(i), 0, 0, "rd_init");
    step(1, 1, 1, 8'hA5, 0, "wr1");
    step(1, 1, 2, 8'h3C, 0, "wr2");
    step(1, 0, 1, 0, 0, "rd1");
    step(1, 0, 2, 0, 0, "rd2");
    step(0, 0, 0, 0, 0, "hold");
    step(1, 1, 3, 8'h77, 0, "wr3");
    step(1, 0, 3, 0, 0, "raw3");
    step(1, 1, 5, 8'hFF, 0, "wr_oor");
    step(1, 0, 5, 0, 0, "rd_oor");
    step(1, 0, 7, 0, 0, "rd_oor7");
    for (int i = 0; i < DEPTH; i++) step(1, 0, 3'(i), 0, 0, "rd_chk");
    for (int i = 0; i < DEPTH; i++) step(1, 1, 3'(i), 8'hFF, 0, "fill");
    step(1, 0, 4, 0, 0, "rd_pre_clr");
    step(0, 0, 0, 0, 1, "clr");
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 2) step(1, 1, 1, 8'h55, 0, "req_busy");
      else if (n == 3) step(0, 0, 0, 0, 1, "clr_busy");
      else step(0, 0, 0, 0, 0, "sweep");
    end
    chk("busy_len", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 3'(i), 0, 0, "rd_clr");
    step(1, 1, 0, 8'h11, 1, "clr_req");
    while (busy) step(0, 0, 0, 0, 0, "sweep2");
    step(1, 0, 0, 0, 0, "rd0_after");
    for (int i = 0; i < DEPTH; i++) step(1, 1, 3'(i), 8'(8'h30 + i), 0, "fill2");
    step(1, 0, 2, 0, 0, "rd_pre");
    step(0, 0, 0, 0, 1, "clr3");
    step(0, 0, 0, 0, 0, "sweep3");
    rst = 1;
    #1;
    model_reset();
    chk("arst.busy", busy, 0);
    chk("arst.ack", ack, 0);
    chk("arst.rdata", rdata, 0);
    #1 rst = 0;
    for (int i = 0; i < DEPTH; i++) step(1, 0, 3'(i), 0, 0, "rd_arst");
`ifdef RAM_BANK_PARITY_EN
    step(1, 1, 2, 8'h01, 0, "p_wr2");
    step(1, 1, 1, 8'h03, 0, "p_wr1");
    force dut.g_w[2].u_w.q = 9'h100;
    #1 release dut.g_w[2].u_w.q;
    mmem[2] = 8'h00;
    mbad[2] = 1;
    step(1, 0, 2, 0, 0, "p_rd2");
    step(1, 0, 1, 0, 0, "p_rd1");
`endif
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 24) == 0, "rand");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
